// File: rtl/cam_emulator_if.sv
// Camera-side bus of the OV7670 emulator: pixel clock, line/frame syncs,
// pixel byte and the end-of-frame pulse.
//   master : the emulator (drives everything)
//   slave  : a capture block (samples on CAM_pclk rising)
interface cam_emulator_if;
  logic       CAM_pclk;
  logic       CAM_href;
  logic       CAM_vsync;
  logic [7:0] CAM_px_data;
  logic       frame_done;

  modport master (output CAM_pclk, CAM_href, CAM_vsync, CAM_px_data, frame_done);
  modport slave  (input  CAM_pclk, CAM_href, CAM_vsync, CAM_px_data, frame_done);
endinterface

// File: rtl/cam_emulator.sv
// OV7670-style camera transmitter emulator: emits QQVGA-sized RGB444 frames
// (two bytes per pixel) built from internal test patterns.
// Ports:
//   clk          system clock, CAM_pclk = clk/2
//   rst          asynchronous active-low reset
//   enable       start / continue frame generation
//   pattern_sel  0/3 solid, 1 colour bars, 2 index ramp (latched per frame)
//   solid_color  RGB444 colour for the solid pattern (latched per frame)
//   cam          camera bus (pclk, href, vsync, px_data, frame_done)
module cam_emulator #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int VS_PULSE     = 8,
  parameter int V_BACK       = 8,
  parameter int H_BLANK      = 16,
  parameter int V_FRONT      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_color,
  cam_emulator_if.master cam
);
  localparam int XW    = $clog2(CAM_SCREEN_X);
  localparam int YW    = $clog2(CAM_SCREEN_Y);
  localparam int BAR_W = CAM_SCREEN_X / 8;
  localparam int M1    = (VS_PULSE > V_BACK)  ? VS_PULSE : V_BACK;
  localparam int M2    = (H_BLANK  > V_FRONT) ? H_BLANK  : V_FRONT;
  localparam int CW    = $clog2(((M1 > M2) ? M1 : M2) + 1);

  // bar colours, index 0 is the leftmost bar
  localparam logic [7:0][11:0] BARS = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                       12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_LINE, S_HBLANK, S_VFRONT} state_t;

  state_t         r_state;
  logic           r_pclk, r_href, r_vsync, r_done, r_phase;
  logic [7:0]     r_data;
  logic [CW-1:0]  r_cnt;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [14:0]    r_idx;
  logic [1:0]     r_pat;
  logic [11:0]    r_solid;

  logic           w_tick, w_cnt_last, w_frame_start, w_line_end;
  logic [CW-1:0]  w_lim;
  logic [XW-1:0]  w_px_x;
  logic [11:0]    w_px_idx, w_px;
  logic [7:0]     w_byte;

  function automatic logic [11:0] f_pix(input logic [1:0] pat, input logic [11:0] solid,
                                        input logic [XW-1:0] x, input logic [11:0] idx);
    logic [2:0] bar;
    bar = 3'(int'(x) / BAR_W);
    case (pat)
      2'd1:    return BARS[bar];
      2'd2:    return idx;
      default: return solid;
    endcase
  endfunction

  // pclk is about to fall on this edge: the only edge where state moves
  assign w_tick = r_pclk;

  always_comb begin
    w_lim = '0;
    case (r_state)
      S_VSYNC:  w_lim = CW'(VS_PULSE - 1);
      S_VBACK:  w_lim = CW'(V_BACK - 1);
      S_HBLANK: w_lim = CW'(H_BLANK - 1);
      S_VFRONT: w_lim = CW'(V_FRONT - 1);
      default:  w_lim = '0;
    endcase
  end

  assign w_cnt_last    = (r_cnt == w_lim);
  assign w_line_end    = r_phase && (r_x == XW'(CAM_SCREEN_X - 1));
  assign w_frame_start = w_tick && enable &&
                         (r_state == S_IDLE || (r_state == S_VFRONT && w_cnt_last));

  // Pixel whose byte goes out after this tick. Phase 0 -> 1 sends the low
  // byte of the current pixel; phase 1 -> 0 sends the high byte of the next.
  // Outside a line it's the first pixel of the coming line (index counter
  // already points at it).
  always_comb begin
    w_px_x   = '0;
    w_px_idx = r_idx[11:0];
    if (r_state == S_LINE && r_phase) begin
      w_px_x   = r_x + 1'b1;
      w_px_idx = r_idx[11:0] + 1'b1;
    end else if (r_state == S_LINE) begin
      w_px_x   = r_x;
    end
  end

  assign w_px   = f_pix(r_pat, r_solid, w_px_x, w_px_idx);
  assign w_byte = (r_state == S_LINE && !r_phase) ? w_px[7:0] : {4'h0, w_px[11:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pclk  <= 1'b0;
      r_href  <= 1'b0;
      r_vsync <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_phase <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_pat   <= '0;
      r_solid <= '0;
    end else begin
      r_pclk <= ~r_pclk;
      r_done <= 1'b0;
      if (w_tick) begin
        if (r_state != S_IDLE && r_state != S_LINE)
          r_cnt <= w_cnt_last ? '0 : CW'(r_cnt + 1'b1);
        case (r_state)
          S_VSYNC: if (w_cnt_last) begin
            r_state <= S_VBACK;
            r_vsync <= 1'b0;
          end
          S_VBACK: if (w_cnt_last) begin
            r_state <= S_LINE;
            r_href  <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
            r_data  <= w_byte;
          end
          S_LINE: begin
            if (w_line_end) begin
              r_state <= S_HBLANK;
              r_href  <= 1'b0;
              r_data  <= '0;
              r_x     <= '0;
              r_phase <= 1'b0;
              r_idx   <= r_idx + 1'b1;
            end else begin
              r_phase <= ~r_phase;
              r_data  <= w_byte;
              if (r_phase) begin
                r_x   <= r_x + 1'b1;
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          S_HBLANK: if (w_cnt_last) begin
            if (r_y == YW'(CAM_SCREEN_Y - 1)) begin
              r_state <= S_VFRONT;
            end else begin
              r_state <= S_LINE;
              r_y     <= r_y + 1'b1;
              r_href  <= 1'b1;
              r_data  <= w_byte;
            end
          end
          S_VFRONT: if (w_cnt_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: ;
        endcase
        // overrides the IDLE fall-through of the last VFRONT tick
        if (w_frame_start) begin
          r_state <= S_VSYNC;
          r_vsync <= 1'b1;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_pat   <= pattern_sel;
          r_solid <= solid_color;
        end
      end
    end
  end

  assign cam.CAM_pclk    = r_pclk;
  assign cam.CAM_href    = r_href;
  assign cam.CAM_vsync   = r_vsync;
  assign cam.CAM_px_data = r_data;
  assign cam.frame_done  = r_done;
endmodule

// File: tb/tb_cam_emulator.sv
// Bench for cam_emulator with a reduced frame geometry. The expected byte
// stream of a frame is built from the frame layout (vsync, back porch,
// lines of 2-byte pixels, hblank, front porch) and compared at every
// CAM_pclk rising edge, as a capture block would see it.
module tb_cam_emulator;
  localparam int X  = 16;
  localparam int Y  = 20;
  localparam int VS = 3;
  localparam int VB = 2;
  localparam int HB = 4;
  localparam int VF = 3;
  localparam int FT = VS + VB + Y * (2 * X + HB) + VF;

  typedef struct { logic v; logic h; logic [7:0] d; } smp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_color = 12'h000;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int n_done = 0;
  smp_t exp_q[$];

  cam_emulator_if cam_if();

  cam_emulator #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .VS_PULSE(VS), .V_BACK(VB),
                 .H_BLANK(HB), .V_FRONT(VF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .cam(cam_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cam_if.frame_done === 1'b1) n_done <= n_done + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] ref_pix(input int pat, input logic [11:0] solid,
                                          input int x, input int y);
    if (pat == 1) begin
      case (x / (X / 8))
        0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
        4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
      endcase
    end
    if (pat == 2) return 12'((y * X + x) % 4096);
    return solid;
  endfunction

  function automatic void push(input logic v, input logic h, input logic [7:0] d);
    smp_t s;
    s.v = v; s.h = h; s.d = d;
    exp_q.push_back(s);
  endfunction

  function automatic void build(input int pat, input logic [11:0] solid);
    logic [11:0] p;
    exp_q.delete();
    repeat (VS) push(1'b1, 1'b0, 8'h00);
    repeat (VB) push(1'b0, 1'b0, 8'h00);
    for (int y = 0; y < Y; y++) begin
      for (int x = 0; x < X; x++) begin
        p = ref_pix(pat, solid, x, y);
        push(1'b0, 1'b1, {4'h0, p[11:8]});
        push(1'b0, 1'b1, p[7:0]);
      end
      repeat (HB) push(1'b0, 1'b0, 8'h00);
    end
    repeat (VF) push(1'b0, 1'b0, 8'h00);
  endfunction

  // advance to the next sample point just after a CAM_pclk rising edge
  task automatic rise();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (cam_if.CAM_pclk !== 1'b1 && k < 4);
    if (cam_if.CAM_pclk !== 1'b1) chk("pclk_rise_timeout", 32'(cam_if.CAM_pclk), 32'd1);
  endtask

  // outputs quiet for n clk; optionally also pclk toggling from a fresh reset
  task automatic idle_chk(input int n, input string tag, input logic with_pclk);
    logic ep;
    ep = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ep = ~ep;
      if (with_pclk) chk({tag, "_pclk"}, 32'(cam_if.CAM_pclk), 32'(ep));
      chk({tag, "_out"}, 32'({cam_if.CAM_href, cam_if.CAM_vsync, cam_if.CAM_px_data,
                              cam_if.frame_done}), 32'd0);
    end
  endtask

  // Check one whole frame. At stream index chg_at the inputs are changed
  // to the values the following frame should latch.
  task automatic check_frame(input int pat, input logic [11:0] solid, input int chg_at,
                             input logic [1:0] n_pat, input logic [11:0] n_solid,
                             input logic n_en, input string tag);
    int k, c0;
    build(pat, solid);
    k = 0;
    while (!(cam_if.CAM_pclk === 1'b1 && cam_if.CAM_vsync === 1'b1) && k < 100) begin
      @(negedge clk); k++;
    end
    chk({tag, "_start"}, 32'(cam_if.CAM_vsync), 32'd1);
    c0 = cyc;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) rise();
      if (i == chg_at) begin
        pattern_sel = n_pat; solid_color = n_solid; enable = n_en;
      end
      chk($sformatf("%s_stream@%0d", tag, i),
          32'({cam_if.CAM_vsync, cam_if.CAM_href, cam_if.CAM_px_data}),
          32'({exp_q[i].v, exp_q[i].h, exp_q[i].d}));
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(cam_if.frame_done), 32'd1);
    // first vsync sample lands one clk after the start tick
    chk({tag, "_len"}, 32'(cyc - c0), 32'(2 * FT - 1));
    chk({tag, "_next_vsync"}, 32'(cam_if.CAM_vsync), 32'(n_en));
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(cam_if.frame_done), 32'd0);
  endtask

  initial begin
    logic [1:0]  rp, np;
    logic [11:0] rs, ns, s1;
    int k;

    // reset held: everything low
    repeat (5) begin
      @(negedge clk);
      chk("reset_out", 32'({cam_if.CAM_pclk, cam_if.CAM_href, cam_if.CAM_vsync,
                            cam_if.CAM_px_data, cam_if.frame_done}), 32'd0);
    end
    rst = 1'b1;
    idle_chk(1000, "idle", 1'b1);

    // index ramp, then bars, then solid 0x5A3 / 0x123 via mid-frame changes
    rs = 12'($urandom);
    s1 = 12'($urandom);
    pattern_sel = 2'd2; solid_color = rs; enable = 1'b1;
    check_frame(2, rs, 300, 2'd1, s1, 1'b1, "ramp");
    check_frame(1, s1, 200, 2'd0, 12'h5A3, 1'b1, "bars");
    check_frame(0, 12'h5A3, 400, 2'd0, 12'h123, 1'b1, "solid5a3");
    rs = 12'($urandom);
    check_frame(0, 12'h123, 100, 2'd3, rs, 1'b1, "solid123");

    // enable dropped during line 10: frame completes, then idle
    np = 2'($urandom_range(0, 3));
    ns = 12'($urandom);
    check_frame(3, rs, VS + VB + 10 * (2 * X + HB) + 5, np, ns, 1'b0, "drop_en");
    idle_chk(40, "post_idle", 1'b0);

    // random back-to-back frames
    rp = 2'($urandom_range(0, 3));
    rs = 12'($urandom);
    pattern_sel = rp; solid_color = rs; enable = 1'b1;
    for (int f = 0; f < 2; f++) begin
      np = 2'($urandom_range(0, 3));
      ns = 12'($urandom);
      check_frame(int'(rp), rs, int'($urandom_range(1, FT - 2)), np, ns, 1'b1,
                  $sformatf("rand%0d", f));
      rp = np; rs = ns;
    end

    // async reset in the middle of a line
    k = 0;
    while (!(cam_if.CAM_pclk === 1'b1 && cam_if.CAM_href === 1'b1) && k < 200) begin
      @(negedge clk); k++;
    end
    chk("midline_href", 32'(cam_if.CAM_href), 32'd1);
    #2 rst = 1'b0;
    #1 chk("async_reset", 32'({cam_if.CAM_pclk, cam_if.CAM_href, cam_if.CAM_vsync,
                               cam_if.CAM_px_data, cam_if.frame_done}), 32'd0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;
    idle_chk(20, "reset_idle", 1'b1);

    rp = 2'($urandom_range(0, 3));
    rs = 12'($urandom);
    pattern_sel = rp; solid_color = rs; enable = 1'b1;
    check_frame(int'(rp), rs, 50, 2'($urandom_range(0, 3)), 12'($urandom), 1'b0, "after_rst");
    repeat (4) @(negedge clk);
    chk("done_pulses", 32'(n_done), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cam_emulator.md
Name: cam_emulator

Overview:
- Synthesizable OV7670-style camera transmitter: generates CAM_pclk, CAM_href, CAM_vsync and CAM_px_data for QQVGA RGB444 frames from internal test patterns.
- Drives the camera capture input of the capture/RAM/VGA path in place of the physical camera, for on-board and simulation bring-up without sensor hardware.
- Sends each pixel as two bytes per the OV7670 RGB444 format. Timing is in CAM_pclk periods.

Parameters:
- CAM_SCREEN_X, 160, pixels per line.
- CAM_SCREEN_Y, 120, lines per frame.
- VS_PULSE, 8, CAM_pclk periods with CAM_vsync high.
- V_BACK, 8, CAM_pclk periods between vsync falling and first HREF.
- H_BLANK, 16, CAM_pclk periods with HREF low after each line.
- V_FRONT, 8, CAM_pclk periods after last line before frame end.

Ports:
- clk  in  1  system clock (24 MHz typical); sole clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  start/continue frame generation.
- pattern_sel  in  2  0 solid, 1 colour bars, 2 index ramp, 3 solid.
- solid_color  in  12  RGB444 value for solid pattern.
- CAM_pclk  out  1  generated pixel clock = clk/2.
- CAM_href  out  1  line-valid.
- CAM_vsync  out  1  frame sync, active high.
- CAM_px_data  out  8  pixel byte.
- frame_done  out  1  one-clk pulse at end of each frame.

Behaviour:
- Reset (rst=0, async): CAM_pclk=0, CAM_href=0, CAM_vsync=0, CAM_px_data=0x00, frame_done=0, state IDLE, all counters 0. Outputs are clean from the first clk edge after rst rises.
- CAM_pclk toggles every clk edge while out of reset (free-running, also in IDLE).
- "tick" = clk edge where CAM_pclk goes 1->0. All state, counters, href, vsync and px_data update only on ticks.
- Data is therefore stable across every CAM_pclk rising edge, which is where the receiver samples.
- States: IDLE -> VSYNC -> VBACK -> LINE <-> HBLANK -> VFRONT -> IDLE/VSYNC.
- IDLE: all outputs low. On a tick with enable=1:
  - latch pattern_sel and solid_color;
  - go to VSYNC with CAM_vsync=1.
- VSYNC: VS_PULSE ticks with CAM_vsync=1, then VBACK with CAM_vsync=0.
- VBACK: V_BACK ticks, then LINE with y=0.
- LINE: CAM_href=1 for 2*CAM_SCREEN_X ticks.
  - Byte phase 0 outputs {4'b0000,R}; phase 1 outputs {G,B} for pixel x.
  - x increments after phase 1.
- HBLANK: CAM_href=0 and CAM_px_data=0x00 for H_BLANK ticks, then y+1.
  - If y was CAM_SCREEN_Y-1, go to VFRONT instead of LINE.
- VFRONT: V_FRONT ticks.
  - On the last tick, frame_done=1 for exactly one clk.
  - Then go to VSYNC if enable=1 (re-latching pattern_sel and solid_color), else IDLE.
- Frame length = VS_PULSE+V_BACK+CAM_SCREEN_Y*(2*CAM_SCREEN_X+H_BLANK)+V_FRONT ticks. Defaults: 40344 ticks = 80688 clk.
- enable deasserted mid-frame: the current frame completes; no truncation.
- pattern_sel/solid_color changes mid-frame are ignored until the next frame start.
- Patterns, pixel value P (12-bit RGB444):
  - Pattern 0/3: P = latched solid_color.
  - Pattern 1: bar = x/(CAM_SCREEN_X/8). Colours: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Pattern 2: P = (y*CAM_SCREEN_X + x) mod 4096, using a running index counter (no multiplier). The counter resets at frame start.
- x counter width: clog2(CAM_SCREEN_X). y counter width: clog2(CAM_SCREEN_Y). The index counter is 15 bits with its low 12 bits used.
- Async reset mid-frame: immediate return to reset values. The next frame starts from VSYNC only after a tick with enable=1.

Test Plan:
- Reset hold 5 clk, release, enable=0: CAM_pclk toggles every clk; href=vsync=0, px_data=0x00 and frame_done=0 for 1000 clk.
- enable=1, pattern_sel=2, defaults:
  - vsync high 8 pclk periods;
  - first HREF 8 pclk after vsync falls;
  - 120 HREF pulses of 320 rising edges each, gaps 16 pclk;
  - frame_done 80688 clk after the start tick.
- Pattern 2 bytes at rising pclk:
  - pixel 0 = 0x00,0x00; pixel 1 = 0x00,0x01; pixel 255 = 0x00,0xFF;
  - pixel 256 = 0x01,0x00; first pixel of line 1 (index 160) = 0x00,0xA0.
- Pattern 1, line 0: pixels 0–19 = 0x0F,0xFF; pixel 20 = 0x0F,0xF0; pixel 140 = 0x00,0x00.
  - Connect to the capture path: RAM address 20 holds 0xFF0.
- pattern_sel=0, solid_color=0x5A3:
  - every line byte pair = 0x05,0xA3;
  - changing solid_color to 0x123 mid-frame leaves the frame at 0x5A3;
  - the next frame uses 0x123.
- Deassert enable during line 50: frame completes (120 lines, frame_done pulses), then IDLE.
  - Assert rst=0 mid-line: all outputs 0 within the same clk, without waiting for a clk edge.
